// File: rtl/seq_sub_ctrl.sv
// Sequential byte-serial subtractor controller.
// Computes a - b over an 8/16/32-bit active width, one byte per clock,
// rippling the borrow from the least significant byte upward.
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - synchronous active-high reset
//   start  - begin one subtraction (accepted in IDLE or DONE only)
//   mode   - 00: 8-bit, 01: 16-bit, 10/11: 32-bit
//   a, b   - minuend / subtrahend, low active-width bits used
//   busy   - high while bytes are being processed
//   done   - one-cycle completion pulse
//   result - difference, zero-extended above the active width
//   borrow - unsigned borrow out of the active width (a < b)
//   ovf    - two's-complement overflow of the active width
//   zero   - active-width result equals zero
module seq_sub_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        borrow,
  output logic        ovf,
  output logic        zero
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    last_idx;
  logic                chain;

  logic [BYTE_W-1:0]   a_byte;
  logic [BYTE_W-1:0]   b_byte;
  logic [BYTE_W:0]     sum;
  logic [BYTE_W-1:0]   diff;
  logic                borrow_out;
  logic [DATA_W-1:0]   res_next;
  logic [IDX_W-1:0]    mode_last;

  // Index of the final byte for the requested width.
  always_comb begin
    case (mode)
      2'b00:   mode_last = 2'd0;
      2'b01:   mode_last = 2'd1;
      default: mode_last = 2'd3;
    endcase
  end

  // One byte of the subtractor: a + ~b + ~borrow_in, carry inverted to borrow.
  always_comb begin
    a_byte     = a_q[{idx, 3'b000} +: BYTE_W];
    b_byte     = b_q[{idx, 3'b000} +: BYTE_W];
    sum        = {1'b0, a_byte} + {1'b0, ~b_byte} + {{BYTE_W{1'b0}}, ~chain};
    diff       = sum[BYTE_W-1:0];
    borrow_out = ~sum[BYTE_W];
    res_next   = result;
    res_next[{idx, 3'b000} +: BYTE_W] = diff;
  end

  // Controller state, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx      <= '0;
      last_idx <= '0;
      chain    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      borrow   <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= RUN;
            a_q      <= a;
            b_q      <= b;
            last_idx <= mode_last;
            idx      <= '0;
            chain    <= 1'b0;
            busy     <= 1'b1;
            result   <= '0;
            borrow   <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          result <= res_next;
          chain  <= borrow_out;
          if (idx == last_idx) begin
            // Final byte: its MSBs are the active-width sign bits.
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            borrow <= borrow_out;
            ovf    <= (a_byte[BYTE_W-1] != b_byte[BYTE_W-1]) &&
                      (diff[BYTE_W-1] != a_byte[BYTE_W-1]);
            zero   <= (res_next == '0);
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sub_ctrl.sv
// Self-checking bench for seq_sub_ctrl: expected results are computed by a
// word-level model when stimulus is issued, queued, and compared on done.
module tb_seq_sub_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        borrow;
  logic        ovf;
  logic        zero;

  seq_sub_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .borrow (borrow),
    .ovf    (ovf),
    .zero   (zero)
  );

  typedef struct {
    logic [31:0] res;
    logic        bor;
    logic        ov;
    logic        z;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert;
  int   n_fail;
  int   cyc;
  int   acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-level reference: mask to active width and subtract directly.
  function automatic exp_t model(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    int          w;
    logic [31:0] mask;
    logic [31:0] xm;
    logic [31:0] ym;
    w     = (m == 2'b00) ? 8 : (m == 2'b01) ? 16 : 32;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xm    = x & mask;
    ym    = y & mask;
    e.res = (xm - ym) & mask;
    e.bor = (xm < ym);
    e.ov  = (xm[w-1] != ym[w-1]) && (e.res[w-1] != xm[w-1]);
    e.z   = (e.res == 32'd0);
    e.lat = w / 8 + 1;
    return e;
  endfunction

  // Present an operation with start high, queue its expectation, and return
  // on the negedge of cycle 1 (acceptance edge just passed).
  task automatic issue(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y, input bit hold);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    a     = x;
    b     = y;
    exp_q.push_back(model(m, x, y));
    @(negedge clk);
    acc = cyc;
    if (!hold) start = 1'b0;
  endtask

  // Bounded wait for done; lat is the cycle number (acceptance cycle = 0).
  task automatic wait_done(output bit seen, output int lat);
    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = cyc - acc + 1;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b1;
    mode  = 2'b00;
    a     = 32'h55;
    b     = 32'h11;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({busy, done, borrow, ovf, zero} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/borrow/ovf/zero=%b required 00000", {busy, done, borrow, ovf, zero});
    end
    n_assert++;
    if (result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h required 00000000", result);
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_vectors;
    logic [1:0]  vm [7];
    logic [31:0] va [7];
    logic [31:0] vb [7];
    exp_t        e;
    bit          seen;
    int          lat;
    vm = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00};
    va = '{32'h05, 32'h0100, 32'h0, 32'h80, 32'h7FFF_FFFF, 32'h8000, 32'hFFFF_FF10};
    vb = '{32'h03, 32'h0001, 32'h1, 32'h01, 32'hFFFF_FFFF, 32'h0001, 32'hAAAA_AA10};
    for (int i = 0; i < 7; i++) begin
      issue(vm[i], va[i], vb[i], 1'b0);
      n_assert++;
      if (busy !== 1'b1 || done !== 1'b0 || result !== 32'd0) begin
        n_fail++;
        $display("FAIL vec%0d_run: got busy=%b done=%b result=%h required 1 0 00000000", i, busy, done, result);
      end
      wait_done(seen, lat);
      e = exp_q.pop_front();
      n_assert++;
      if (!seen || lat != e.lat) begin
        n_fail++;
        $display("FAIL vec%0d_latency: got seen=%0d cycle=%0d required cycle %0d", i, seen, lat, e.lat);
      end
      n_assert++;
      if (result !== e.res || borrow !== e.bor || ovf !== e.ov || zero !== e.z || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_out: got res=%h bor=%b ovf=%b z=%b busy=%b required %h %b %b %b 0",
                 i, result, borrow, ovf, zero, busy, e.res, e.bor, e.ov, e.z);
      end
      a = 32'hDEAD_BEEF;
      b = 32'h0BAD_F00D;
      @(negedge clk);
      n_assert++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== e.res || borrow !== e.bor || ovf !== e.ov || zero !== e.z) begin
        n_fail++;
        $display("FAIL vec%0d_hold: got done=%b busy=%b res=%h required 0 0 %h", i, done, busy, result, e.res);
      end
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int   n_done;
    int   lat;
    issue(2'b11, 32'h1234_5678, 32'h1234_5678, 1'b0);
    e      = exp_q.pop_front();
    n_done = 0;
    lat    = -1;
    start  = 1'b1;
    mode   = 2'b00;
    a      = 32'hFF;
    b      = 32'h01;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        n_done++;
        if (lat < 0) begin
          lat = cyc - acc + 1;
          n_assert++;
          if (result !== e.res || zero !== e.z || borrow !== e.bor || ovf !== e.ov) begin
            n_fail++;
            $display("FAIL ignore_out: got res=%h z=%b bor=%b ovf=%b required %h %b %b %b",
                     result, zero, borrow, ovf, e.res, e.z, e.bor, e.ov);
          end
        end
      end
      @(negedge clk);
    end
    n_assert++;
    if (n_done != 1 || lat != 5) begin
      n_fail++;
      $display("FAIL ignore_done: got %0d pulses first in cycle %0d required 1 pulse in cycle 5", n_done, lat);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit   seen;
    int   lat;
    issue(2'b00, 32'hC8, 32'h37, 1'b1);
    mode = 2'b01;
    a    = 32'h1234;
    b    = 32'h5678;
    exp_q.push_back(model(2'b01, 32'h1234, 32'h5678));
    @(negedge clk);
    e = exp_q.pop_front();
    n_assert++;
    if (done !== 1'b1 || result !== e.res || borrow !== e.bor || ovf !== e.ov || zero !== e.z) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b res=%h bor=%b required 1 %h %b", done, result, borrow, e.res, e.bor);
    end
    @(negedge clk);
    acc   = cyc;
    start = 1'b0;
    n_assert++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_no_idle: got busy=%b done=%b result=%h required 1 0 00000000", busy, done, result);
    end
    wait_done(seen, lat);
    e = exp_q.pop_front();
    n_assert++;
    if (!seen || lat != e.lat || result !== e.res || borrow !== e.bor || ovf !== e.ov || zero !== e.z) begin
      n_fail++;
      $display("FAIL b2b_second: got seen=%0d cycle=%0d res=%h bor=%b required cycle %0d %h %b",
               seen, lat, result, borrow, e.lat, e.res, e.bor);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit   seen;
    int   lat;
    int   n_done;
    issue(2'b10, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({busy, done, borrow, ovf, zero} !== 5'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got busy/done/borrow/ovf/zero=%b result=%h required 00000 00000000",
               {busy, done, borrow, ovf, zero}, result);
    end
    rst = 1'b0;
    exp_q.delete();
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_assert++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL midrst_no_done: got %0d done pulses required 0", n_done);
    end
    issue(2'b00, 32'h3C, 32'h5A, 1'b0);
    wait_done(seen, lat);
    e = exp_q.pop_front();
    n_assert++;
    if (!seen || lat != 2 || result !== e.res || borrow !== e.bor || ovf !== e.ov || zero !== e.z) begin
      n_fail++;
      $display("FAIL midrst_after: got seen=%0d cycle=%0d res=%h bor=%b ovf=%b required cycle 2 %h %b %b",
               seen, lat, result, borrow, ovf, e.res, e.bor, e.ov);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    acc      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 2'b00;
    a        = 32'd0;
    b        = 32'd0;
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
